// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between instruction fetch and load/store requesters
module mem_port_arbiter #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8,
  parameter int p_ARB_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_ADDR_BITS-1:0] imem_addr,
  input  logic [1:0]             imem_size,
  input  logic                   imem_valid,
  output logic                   imem_ready,
  input  logic                   imem_r_ready,
  output logic                   imem_r_valid,
  output logic [p_DATA_BITS-1:0] imem_r_data,
  output logic                   imem_r_resp,
  input  logic [p_ADDR_BITS-1:0] dmem_addr,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_size,
  input  logic                   dmem_valid,
  output logic                   dmem_ready,
  input  logic                   dmem_r_ready,
  output logic                   dmem_r_valid,
  output logic [p_DATA_BITS-1:0] dmem_r_data,
  output logic                   dmem_r_resp,
  input  logic                   dmem_w_valid,
  output logic                   dmem_w_ready,
  input  logic [p_STRB_BITS-1:0] dmem_w_strb,
  input  logic [p_DATA_BITS-1:0] dmem_w_data,
  output logic                   dmem_w_resp,
  output logic [p_ADDR_BITS-1:0] m_addr,
  output logic                   m_cmd,
  output logic [1:0]             m_size,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   m_r_valid,
  input  logic [p_DATA_BITS-1:0] m_r_data,
  input  logic                   m_r_resp,
  output logic                   m_r_ready,
  output logic                   m_w_valid,
  output logic [p_STRB_BITS-1:0] m_w_strb,
  output logic [p_DATA_BITS-1:0] m_w_data,
  input  logic                   m_w_ready,
  input  logic                   m_w_resp,
  output logic                   grant
);
  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, cmd_q, cmd_d;
  logic [p_ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic idle, rd, wr, pick;
  assign idle = state_q == IDLE;
  assign rd   = state_q == RDATA;
  assign wr   = state_q == WDATA;
  // winner of the IDLE arbitration: 1 = dmem; a round-robin tie goes to whoever did not win last
  assign pick = (p_ARB_MODE != 0) ? dmem_valid : ((imem_valid && dmem_valid) ? !last_q : dmem_valid);
  assign imem_ready   = idle && imem_valid && !pick;
  assign dmem_ready   = idle && dmem_valid && pick;
  assign m_addr       = addr_q;
  assign m_cmd        = cmd_q;
  assign m_size       = size_q;
  assign m_valid      = state_q == CMD;
  assign grant        = grant_q;
  assign m_r_ready    = rd && (grant_q ? dmem_r_ready : imem_r_ready);
  assign imem_r_valid = rd && !grant_q && m_r_valid;
  assign imem_r_data  = (rd && !grant_q) ? m_r_data : '0;
  assign imem_r_resp  = rd && !grant_q && m_r_resp;
  assign dmem_r_valid = rd && grant_q && m_r_valid;
  assign dmem_r_data  = (rd && grant_q) ? m_r_data : '0;
  assign dmem_r_resp  = rd && grant_q && m_r_resp;
  assign m_w_valid    = wr && dmem_w_valid;
  assign m_w_strb     = dmem_w_strb;
  assign m_w_data     = dmem_w_data;
  assign dmem_w_ready = wr && m_w_ready;
  assign dmem_w_resp  = wr && m_w_resp;
  // next-state: accept and buffer a command in IDLE, then walk command and data phases back to IDLE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    size_d  = size_q;
    if (idle && (imem_valid || dmem_valid)) begin
      state_d = CMD;
      grant_d = pick;
      last_d  = pick;
      addr_d  = pick ? dmem_addr : imem_addr;
      cmd_d   = pick && dmem_cmd;
      size_d  = pick ? dmem_size : imem_size;
    end else if (state_q == CMD && m_ready)
      state_d = cmd_q ? WDATA : RDATA;
    else if ((rd && m_r_valid && m_r_ready) || (wr && m_w_valid && m_w_ready))
      state_d = IDLE;
  end
  // state and command buffer; last grant resets to dmem so imem wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      size_q  <= size_d;
    end
  end
endmodule
